// File: rtl/cmdeve_responder_if.sv
// Command, event and data-mover handshake bundle for cmdeve_responder.
// The slave modport is the responder's view; master is its environment.
interface cmdeve_responder_if;
    logic         s_axis_cmd_valid;
    logic [63:0]  s_axis_cmd_data;
    logic         s_axis_cmd_ready;
    logic         m_axis_eve_valid;
    logic [127:0] m_axis_eve_data;
    logic         m_axis_eve_ready;
    logic         dm_req_valid;
    logic [31:0]  dm_req_len;
    logic [15:0]  dm_req_tag;
    logic         dm_req_ready;
    logic         dm_done_valid;
    logic [31:0]  dm_done_bytes;
    logic         dm_done_err;
    logic         dm_done_ready;

    modport slave (
        input  s_axis_cmd_valid, s_axis_cmd_data,
        input  m_axis_eve_ready, dm_req_ready,
        input  dm_done_valid, dm_done_bytes, dm_done_err,
        output s_axis_cmd_ready, m_axis_eve_valid, m_axis_eve_data,
        output dm_req_valid, dm_req_len, dm_req_tag, dm_done_ready
    );

    modport master (
        output s_axis_cmd_valid, s_axis_cmd_data,
        output m_axis_eve_ready, dm_req_ready,
        output dm_done_valid, dm_done_bytes, dm_done_err,
        input  s_axis_cmd_ready, m_axis_eve_valid, m_axis_eve_data,
        input  dm_req_valid, dm_req_len, dm_req_tag, dm_done_ready
    );
endinterface

// File: rtl/cmdeve_responder.sv
// Command endpoint: issues transfers to the data mover and returns one
// in-order 128-bit event per accepted command.
module cmdeve_responder #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 32
) (
    input  logic              ext_clk,
    input  logic              ext_reset_n,
    cmdeve_responder_if.slave bus,
    output logic              orphan_done,
    output logic [4:0]        outstanding
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             en_q;
    logic [LEN_W-1:0] len_q [DEPTH];
    logic [15:0]      tag_q [DEPTH];
    logic [DEPTH-1:0] zl_q;
    logic [AW-1:0]    wr_q, rd_q;
    logic [4:0]       cnt_q, cnt_d;

    logic             req_vld_q, req_vld_d;
    logic [LEN_W-1:0] req_len_q, req_len_d;
    logic [15:0]      req_tag_q, req_tag_d;

    logic             eve_vld_q, eve_vld_d;
    logic [127:0]     eve_q, eve_d;
    logic [7:0]       seq_q, seq_d;
    logic             orph_q, orph_d;

    logic [LEN_W-1:0] c_len, h_len, ev_bytes;
    logic [15:0]      c_tag, h_tag;
    logic             h_zl, head_vld, full, eve_free;
    logic             cmd_rdy, done_rdy;
    logic             push, pop, done_hs, zl_gen;
    logic [7:0]       st;
    logic             unused_rsvd;

    assign c_len       = bus.s_axis_cmd_data[31:0];
    assign c_tag       = bus.s_axis_cmd_data[47:32];
    assign unused_rsvd = ^bus.s_axis_cmd_data[63:48];

    assign h_len    = len_q[rd_q];
    assign h_tag    = tag_q[rd_q];
    assign h_zl     = zl_q[rd_q];
    assign head_vld = (cnt_q != 5'd0);
    assign full     = (cnt_q == 5'(DEPTH));
    assign eve_free = !eve_vld_q || bus.m_axis_eve_ready;

    // en_q keeps every ready low while reset is held
    assign cmd_rdy  = en_q && !full && (!req_vld_q || bus.dm_req_ready);
    assign done_rdy = en_q && (!head_vld || (!h_zl && eve_free));

    assign push    = bus.s_axis_cmd_valid && cmd_rdy;
    assign done_hs = bus.dm_done_valid && done_rdy && head_vld;
    assign zl_gen  = en_q && head_vld && h_zl && eve_free;
    assign pop     = done_hs || zl_gen;

    assign ev_bytes = zl_gen ? '0 : bus.dm_done_bytes;

    always_comb begin
        st = 8'h00;
        if (zl_gen) begin
            st = 8'h04;
        end else begin
            st[0] = bus.dm_done_err;
            st[1] = bus.dm_done_bytes < h_len;
            st[3] = bus.dm_done_bytes > h_len;
        end
    end

    always_comb begin
        cnt_d     = cnt_q + 5'(push) - 5'(pop);
        req_vld_d = req_vld_q;
        req_len_d = req_len_q;
        req_tag_d = req_tag_q;
        eve_vld_d = eve_vld_q;
        eve_d     = eve_q;
        seq_d     = seq_q;
        orph_d    = orph_q;

        if (push && c_len != '0) begin
            req_vld_d = 1'b1;
            req_len_d = c_len;
            req_tag_d = c_tag;
        end else if (bus.dm_req_ready) begin
            req_vld_d = 1'b0;
        end

        if (pop) begin
            eve_vld_d = 1'b1;
            eve_d     = {32'd0, seq_q, st, h_tag, ev_bytes, h_len};
            seq_d     = seq_q + 8'd1;
        end else if (bus.m_axis_eve_ready) begin
            eve_vld_d = 1'b0;
        end

        if (bus.dm_done_valid && done_rdy && !head_vld) begin
            orph_d = 1'b1;
        end
    end

    always_ff @(posedge ext_clk or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            en_q      <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            req_vld_q <= 1'b0;
            req_len_q <= '0;
            req_tag_q <= '0;
            eve_vld_q <= 1'b0;
            eve_q     <= '0;
            seq_q     <= '0;
            orph_q    <= 1'b0;
        end else begin
            en_q      <= 1'b1;
            wr_q      <= push ? wr_q + AW'(1) : wr_q;
            rd_q      <= pop ? rd_q + AW'(1) : rd_q;
            cnt_q     <= cnt_d;
            req_vld_q <= req_vld_d;
            req_len_q <= req_len_d;
            req_tag_q <= req_tag_d;
            eve_vld_q <= eve_vld_d;
            eve_q     <= eve_d;
            seq_q     <= seq_d;
            orph_q    <= orph_d;
        end
    end

    // queue payload needs no reset; occupancy alone defines validity
    always_ff @(posedge ext_clk) begin
        if (push) begin
            len_q[wr_q] <= c_len;
            tag_q[wr_q] <= c_tag;
            zl_q[wr_q]  <= (c_len == '0);
        end
    end

    assign bus.s_axis_cmd_ready = cmd_rdy;
    assign bus.dm_done_ready    = done_rdy;
    assign bus.dm_req_valid     = req_vld_q;
    assign bus.dm_req_len       = req_len_q;
    assign bus.dm_req_tag       = req_tag_q;
    assign bus.m_axis_eve_valid = eve_vld_q;
    assign bus.m_axis_eve_data  = eve_q;
    assign orphan_done          = orph_q;
    assign outstanding          = cnt_q;
endmodule

// File: tb/tb_cmdeve_responder.sv
// Directed and randomized bench for cmdeve_responder with an in-order
// command/completion model producing the expected event stream.
module tb_cmdeve_responder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       orphan;
    logic [4:0] outst;

    always #5 clk = ~clk;

    cmdeve_responder_if bus ();

    cmdeve_responder #(.DEPTH(4), .LEN_W(32)) dut (
        .ext_clk    (clk),
        .ext_reset_n(rst_n),
        .bus        (bus),
        .orphan_done(orphan),
        .outstanding(outst)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_ev  = 0;
    int n_req = 0;
    logic [7:0] eseq = 8'd0;
    bit cmd_hs = 0, done_hs = 0;

    logic [47:0] acc_q[$];
    logic [47:0] nz_q[$];
    logic [47:0] pend_q[$];
    logic [32:0] done_q[$];

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_eve(logic [47:0] c,
                                               logic [32:0] d,
                                               logic [7:0] s);
        logic [31:0] len, bytes;
        logic [7:0]  st;
        len   = c[31:0];
        bytes = (len == 0) ? 32'd0 : d[31:0];
        if (len == 0) st = 8'd4;
        else st = 8'(d[32]) + (bytes < len ? 8'd2 : 8'd0)
                  + (bytes > len ? 8'd8 : 8'd0);
        return {32'd0, s, st, c[47:32], bytes, len};
    endfunction

    task automatic check_eve(input logic [127:0] data);
        bit have;
        logic [47:0] c;
        logic [32:0] d;
        have = (acc_q.size() != 0);
        chk("eve_has_cmd", 128'(have), 128'd1);
        if (have) begin
            c = acc_q.pop_front();
            d = '0;
            if (c[31:0] != 0) begin
                have = (done_q.size() != 0);
                chk("eve_has_done", 128'(have), 128'd1);
                if (have) d = done_q.pop_front();
            end
            chk("event", data, model_eve(c, d, eseq));
            eseq++;
            n_ev++;
        end
    endtask

    task automatic step();
        bit rq, ev;
        logic [47:0] c;
        @(negedge clk);
        cmd_hs  = bus.s_axis_cmd_valid && bus.s_axis_cmd_ready;
        done_hs = bus.dm_done_valid && bus.dm_done_ready;
        rq = bus.dm_req_valid && bus.dm_req_ready;
        ev = bus.m_axis_eve_valid && bus.m_axis_eve_ready;
        if (cmd_hs) begin
            c = bus.s_axis_cmd_data[47:0];
            acc_q.push_back(c);
            if (c[31:0] != 0) nz_q.push_back(c);
        end
        if (rq) begin
            n_req++;
            c = (nz_q.size() != 0) ? nz_q.pop_front() : 48'hx;
            chk("dm_req", {bus.dm_req_tag, bus.dm_req_len}, c);
            pend_q.push_back({bus.dm_req_tag, bus.dm_req_len});
        end
        if (done_hs && pend_q.size() != 0) begin
            done_q.push_back({bus.dm_done_err, bus.dm_done_bytes});
            void'(pend_q.pop_front());
        end
        if (ev) check_eve(bus.m_axis_eve_data);
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] len, input logic [15:0] tag);
        bit ok = 0;
        bus.s_axis_cmd_valid = 1'b1;
        bus.s_axis_cmd_data  = {16'($urandom), tag, len};
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = cmd_hs;
        end
        bus.s_axis_cmd_valid = 1'b0;
        chk("cmd_accept", 128'(ok), 128'd1);
    endtask

    task automatic send_done(input logic [31:0] bytes, input logic err);
        bit ok = 0;
        bus.dm_done_valid = 1'b1;
        bus.dm_done_bytes = bytes;
        bus.dm_done_err   = err;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = done_hs;
        end
        bus.dm_done_valid = 1'b0;
        chk("done_accept", 128'(ok), 128'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 128'(bus.s_axis_cmd_ready), 0);
        chk({tag, "_eve_valid"}, 128'(bus.m_axis_eve_valid), 0);
        chk({tag, "_eve_data"}, bus.m_axis_eve_data, 0);
        chk({tag, "_req_valid"}, 128'(bus.dm_req_valid), 0);
        chk({tag, "_req_len"}, 128'(bus.dm_req_len), 0);
        chk({tag, "_done_ready"}, 128'(bus.dm_done_ready), 0);
        chk({tag, "_orphan"}, 128'(orphan), 0);
        chk({tag, "_outstanding"}, 128'(outst), 0);
    endtask

    initial begin
        logic [127:0] snap;
        logic [47:0]  p;
        int e0, r0;
        bus.s_axis_cmd_valid = 0;
        bus.s_axis_cmd_data  = '0;
        bus.m_axis_eve_ready = 0;
        bus.dm_req_ready     = 0;
        bus.dm_done_valid    = 0;
        bus.dm_done_bytes    = '0;
        bus.dm_done_err      = 0;

        // reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single transfer
        send_cmd(32'h100, 16'h0A);
        chk("t1_req_valid", 128'(bus.dm_req_valid), 1);
        chk("t1_req_len", 128'(bus.dm_req_len), 128'h100);
        chk("t1_req_tag", 128'(bus.dm_req_tag), 128'h0A);
        step();
        step();
        chk("t1_req_hold", {bus.dm_req_valid, bus.dm_req_tag,
                            bus.dm_req_len}, {1'b1, 16'h0A, 32'h100});
        bus.dm_req_ready = 1;
        step();
        send_done(32'h100, 0);
        chk("t1_eve_valid", 128'(bus.m_axis_eve_valid), 1);
        chk("t1_eve_data", bus.m_axis_eve_data,
            {32'd0, 8'd0, 8'd0, 16'h0A, 32'h100, 32'h100});
        bus.m_axis_eve_ready = 1;
        step();
        bus.m_axis_eve_ready = 0;

        // queue full blocks the fifth command
        for (int i = 0; i < 4; i++) send_cmd(32'(i + 1), 16'(16'h20 + i));
        bus.s_axis_cmd_valid = 1;
        bus.s_axis_cmd_data  = {16'h0, 16'h24, 32'd5};
        for (int i = 0; i < 3; i++) begin
            chk("full_ready", 128'(bus.s_axis_cmd_ready), 0);
            chk("full_outst", 128'(outst), 4);
            step();
        end
        bus.m_axis_eve_ready = 1;
        bus.dm_done_valid    = 1;
        bus.dm_done_bytes    = 32'd1;
        bus.dm_done_err      = 0;
        step();
        bus.dm_done_valid = 0;
        chk("freed_ready", 128'(bus.s_axis_cmd_ready), 1);
        step();
        chk("fifth_accept", 128'(cmd_hs), 1);
        bus.s_axis_cmd_valid = 0;
        for (int k = 0; k < 10 && pend_q.size() != 0; k++) begin
            p = pend_q[0];
            send_done(p[31:0], 0);
        end
        for (int i = 0; i < 4; i++) step();
        chk("t2_outst", 128'(outst), 0);
        chk("t2_model_empty", 128'(acc_q.size()), 0);

        // zero-length command between two real ones
        r0 = n_req;
        send_cmd(32'd8, 16'd0);
        send_cmd(32'd0, 16'd1);
        send_cmd(32'd8, 16'd2);
        for (int i = 0; i < 3; i++) step();
        chk("zl_req_count", 128'(n_req - r0), 2);
        send_done(32'd8, 0);
        send_done(32'd8, 0);
        for (int i = 0; i < 4; i++) step();
        chk("zl_model_empty", 128'(acc_q.size()), 0);

        // short+error and overrun status
        bus.m_axis_eve_ready = 0;
        send_cmd(32'd8, 16'd3);
        send_cmd(32'd8, 16'd4);
        step();
        step();
        send_done(32'd4, 1);
        chk("st_short_err", 128'(bus.m_axis_eve_data[87:80]), 128'h03);
        chk("st_short_bytes", 128'(bus.m_axis_eve_data[63:32]), 4);
        bus.m_axis_eve_ready = 1;
        send_done(32'd12, 0);
        bus.m_axis_eve_ready = 0;
        chk("st_overrun", 128'(bus.m_axis_eve_data[87:80]), 128'h08);
        bus.m_axis_eve_ready = 1;
        step();

        // held event back-pressures completions
        bus.m_axis_eve_ready = 0;
        send_cmd(32'd16, 16'd5);
        send_cmd(32'd16, 16'd6);
        step();
        step();
        send_done(32'd16, 0);
        snap = bus.m_axis_eve_data;
        bus.dm_done_valid = 1;
        bus.dm_done_bytes = 32'd16;
        bus.dm_done_err   = 0;
        for (int i = 0; i < 10; i++) begin
            chk("hold_done_ready", 128'(bus.dm_done_ready), 0);
            chk("hold_eve", {bus.m_axis_eve_valid, bus.m_axis_eve_data},
                {1'b1, snap});
            step();
        end
        e0 = n_ev;
        bus.m_axis_eve_ready = 1;
        step();
        bus.dm_done_valid = 0;
        chk("b2b_first", 128'(n_ev - e0), 1);
        chk("b2b_valid", 128'(bus.m_axis_eve_valid), 1);
        step();
        chk("b2b_second", 128'(n_ev - e0), 2);

        // orphan completion
        chk("orph_empty", 128'(outst), 0);
        e0 = n_ev;
        bus.dm_done_valid = 1;
        bus.dm_done_bytes = 32'h55;
        step();
        bus.dm_done_valid = 0;
        chk("orph_set", 128'(orphan), 1);
        chk("orph_no_eve", 128'(bus.m_axis_eve_valid), 0);
        for (int i = 0; i < 3; i++) step();
        chk("orph_sticky", 128'(orphan), 1);
        chk("orph_no_count", 128'(n_ev - e0), 0);

        // reset with commands in flight
        send_cmd(32'd32, 16'd7);
        send_cmd(32'd32, 16'd8);
        send_cmd(32'd32, 16'd9);
        chk("rst_outst3", 128'(outst), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        acc_q.delete();
        nz_q.delete();
        pend_q.delete();
        done_q.delete();
        eseq = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        e0 = n_ev;
        for (int i = 0; i < 10; i++) step();
        chk("no_stale_eve", 128'(n_ev - e0), 0);

        // randomized traffic against the model
        e0 = n_ev;
        cmd_hs  = 0;
        done_hs = 0;
        for (int it = 0; it < 2000; it++) begin
            if (!bus.s_axis_cmd_valid || cmd_hs) begin
                bus.s_axis_cmd_valid = 1'($urandom_range(1, 0));
                bus.s_axis_cmd_data  = {16'($urandom), 16'($urandom),
                    ($urandom_range(3, 0) == 0) ? 32'd0
                        : 32'($urandom_range(64, 1))};
            end
            bus.dm_req_ready     = ($urandom_range(3, 0) != 0);
            bus.m_axis_eve_ready = ($urandom_range(3, 0) != 0);
            if (!bus.dm_done_valid || done_hs) begin
                bus.dm_done_valid = 0;
                if (pend_q.size() != 0 && $urandom_range(1, 0) == 1) begin
                    p = pend_q[0];
                    bus.dm_done_valid = 1;
                    bus.dm_done_err   = ($urandom_range(7, 0) == 0);
                    case ($urandom_range(3, 0))
                        0: bus.dm_done_bytes = p[31:0];
                        1: bus.dm_done_bytes = p[31:0] - 32'd1;
                        2: bus.dm_done_bytes =
                               p[31:0] + 32'($urandom_range(5, 1));
                        default: bus.dm_done_bytes = $urandom;
                    endcase
                end
            end
            step();
        end
        bus.s_axis_cmd_valid = 0;
        bus.dm_req_ready     = 1;
        bus.m_axis_eve_ready = 1;
        for (int k = 0; k < 500; k++) begin
            if (!bus.dm_done_valid || done_hs) begin
                bus.dm_done_valid = 0;
                if (pend_q.size() != 0) begin
                    p = pend_q[0];
                    bus.dm_done_valid = 1;
                    bus.dm_done_bytes = p[31:0];
                    bus.dm_done_err   = 0;
                end
            end
            if (!bus.dm_done_valid && acc_q.size() == 0) break;
            step();
        end
        bus.dm_done_valid = 0;
        step();
        chk("rnd_outst", 128'(outst), 0);
        chk("rnd_model_empty", 128'(acc_q.size()), 0);
        chk("rnd_no_orphan", 128'(orphan), 0);
        chk("rnd_seq_wrapped", 128'(n_ev - e0 > 256), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
